bcd_excess3_seq_ctrl: RTL and testbench
=======================================

BCD_EXCESS3_SEQ_CTRL -- requirements
Module: bcd_excess3_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: NDIG, default 4, number of BCD digits per word (legal range 1..8).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset; synchronous and active-high.
REQ-004 The block SHALL have the port in_valid, input, 1 bit: the input word is offered.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: the block can accept a word.
REQ-006 The block SHALL have the port in_bcd, input, 4*NDIG bits: packed BCD word, digit 0 in bits [3:0].
REQ-007 The block SHALL have the port out_valid, output, 1 bit: a result is presented.
REQ-008 The block SHALL have the port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have the port out_xs3, output, 4*NDIG bits: packed Excess-3 result, same digit order as in_bcd.
REQ-010 The block SHALL have the port out_err, output, 1 bit: at least one input digit was greater than 9.
REQ-011 The block SHALL have the port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 The block SHALL implement a 3-state FSM: IDLE, CONV, DONE.
REQ-013 In IDLE, in_ready SHALL be 1; in CONV and DONE, in_ready SHALL be 0.
REQ-014 An input handshake occurs at a rising edge where in_valid=1 and in_ready=1; on it the block SHALL capture in_bcd, clear the result register and the error flag, set the digit index to 0, and go to CONV.
REQ-015 In CONV, the block SHALL process exactly one digit per cycle through a single shared 4-bit converter, digit 0 first.
REQ-016 The converter SHALL compute xs3 = (digit + 3) mod 16; a carry out of bit 3 is discarded.
REQ-017 The converted nibble SHALL be written into result nibble position [index].
REQ-018 If the processed digit is greater than 9, out_err SHALL be set sticky.
- The nibble is still written as (digit + 3) mod 16; there is no saturation and no abort.
REQ-019 After the digit at index NDIG-1 has been processed, the block SHALL go to DONE; the index SHALL NOT wrap or overrun.
REQ-020 Latency: with acceptance at edge T0, out_valid SHALL rise after edge T0+NDIG, i.e. NDIG cycles later (4 for the default).
REQ-021 In DONE, out_valid SHALL be 1, and out_xs3 and out_err SHALL remain stable until the output handshake (out_valid=1 and out_ready=1 at an edge).
REQ-022 On the output handshake, the block SHALL go to IDLE; in_ready SHALL be 1 in the following cycle. There is no bypass to CONV from DONE.
REQ-023 in_valid asserted during CONV or DONE SHALL be ignored; the captured word SHALL NOT change.
REQ-024 out_ready asserted outside DONE SHALL have no effect.
REQ-025 out_xs3 and out_err SHALL hold the last result in IDLE until the next input handshake clears them.
REQ-026 busy SHALL be 1 in CONV and DONE and 0 in IDLE.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL enter IDLE and set the digit index to 0.
REQ-028 The reset values of the outputs SHALL be: out_valid=0, out_xs3=0, out_err=0, busy=0, in_ready=1.
REQ-029 rst SHALL override every other input at the same edge, including a simultaneous handshake.
REQ-030 A reset during CONV or DONE SHALL discard the in-flight word; no out_valid pulse SHALL follow it.

Verification
REQ-031 The bench SHALL cover: in_bcd=0x0369 accepted with out_ready=1 -> after 4 cycles out_xs3=0x369C, out_err=0, out_valid high for 1 cycle.
REQ-032 The bench SHALL cover: in_bcd=0x9999 -> out_xs3=0xCCCC, out_err=0; in_bcd=0x0000 -> out_xs3=0x3333, out_err=0.
REQ-033 The bench SHALL cover: in_bcd=0x0A12 -> out_xs3=0x3D45, out_err=1; in_bcd=0xF000 -> out_xs3=0x2333, out_err=1.
REQ-034 The bench SHALL cover: out_ready held low 3 cycles in DONE -> out_valid, out_xs3 and out_err stable for those cycles; handshake on the 4th; in_ready=1 on the next cycle.
REQ-035 The bench SHALL cover: in_valid toggled with a new word during CONV -> it is ignored and the result matches the first word; a back-to-back second word is accepted only after return to IDLE.
REQ-036 The bench SHALL cover: rst pulsed at the 2nd CONV cycle -> next cycle state is IDLE, in_ready=1, out_valid=0, out_xs3=0, and no result is ever emitted for that word.

Source files
------------

// File: rtl/bcd_excess3_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_excess3_seq_ctrl
// Description : Sequential packed-BCD to Excess-3 converter. A word is
//               captured on a valid/ready handshake, converted one digit per
//               cycle (digit 0 first) through a single shared 4-bit adder,
//               and presented with a sticky invalid-digit flag until the
//               consumer accepts it.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_excess3_seq_ctrl #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_bcd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] out_xs3,
    output logic              out_err,
    output logic              busy
);

    // Digit index width; a single-digit build still needs a 1-bit index.
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NDIG - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);
    localparam logic [3:0]       c_XS3_BIAS = 4'd3;
    localparam logic [3:0]       c_BCD_MAX  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Registered state
    state_t              r_state_q;
    logic [IDX_W-1:0]    r_idx_q;
    logic [4*NDIG-1:0]   r_word_q;
    logic [4*NDIG-1:0]   r_result_q;
    logic                r_err_q;
    logic                r_out_valid_q;
    logic                r_in_ready_q;
    logic                r_busy_q;

    // Next-state values
    state_t              w_state_d;
    logic [IDX_W-1:0]    w_idx_d;
    logic [4*NDIG-1:0]   w_word_d;
    logic [4*NDIG-1:0]   w_result_d;
    logic                w_err_d;
    logic                w_out_valid_d;
    logic                w_in_ready_d;
    logic                w_busy_d;

    // Shared converter datapath
    logic [3:0]          w_digit;
    logic [3:0]          w_xs3;
    logic                w_digit_bad;

    // Select the current digit and bias it by 3; the adder carry is dropped
    // so out-of-range digits simply wrap rather than saturate.
    always_comb begin
        w_digit     = r_word_q[{r_idx_q, 2'b00} +: 4];
        w_xs3       = w_digit + c_XS3_BIAS;
        w_digit_bad = (w_digit > c_BCD_MAX);
    end

    // Next-state and next-output computation for the IDLE/CONV/DONE sequencer.
    always_comb begin
        w_state_d     = r_state_q;
        w_idx_d       = r_idx_q;
        w_word_d      = r_word_q;
        w_result_d    = r_result_q;
        w_err_d       = r_err_q;
        w_out_valid_d = r_out_valid_q;
        w_in_ready_d  = r_in_ready_q;
        w_busy_d      = r_busy_q;

        case (r_state_q)
            S_IDLE: begin
                // Previous result stays visible until a new word arrives.
                if (in_valid && r_in_ready_q) begin
                    w_word_d      = in_bcd;
                    w_result_d    = '0;
                    w_err_d       = 1'b0;
                    w_idx_d       = '0;
                    w_state_d     = S_CONV;
                    w_in_ready_d  = 1'b0;
                    w_busy_d      = 1'b1;
                end
            end

            S_CONV: begin
                // One nibble per cycle; in_valid is not looked at here.
                w_result_d[{r_idx_q, 2'b00} +: 4] = w_xs3;
                w_err_d = r_err_q | w_digit_bad;
                if (r_idx_q == c_LAST_IDX) begin
                    w_state_d     = S_DONE;
                    w_out_valid_d = 1'b1;
                end else begin
                    w_idx_d = r_idx_q + c_IDX_ONE;
                end
            end

            S_DONE: begin
                // Result held until accepted; always return through IDLE.
                if (out_ready) begin
                    w_state_d     = S_IDLE;
                    w_out_valid_d = 1'b0;
                    w_in_ready_d  = 1'b1;
                    w_busy_d      = 1'b0;
                end
            end

            default: begin
                w_state_d     = S_IDLE;
                w_idx_d       = '0;
                w_out_valid_d = 1'b0;
                w_in_ready_d  = 1'b1;
                w_busy_d      = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_idx_q       <= '0;
            r_word_q      <= '0;
            r_result_q    <= '0;
            r_err_q       <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_in_ready_q  <= 1'b1;
            r_busy_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_idx_q       <= w_idx_d;
            r_word_q      <= w_word_d;
            r_result_q    <= w_result_d;
            r_err_q       <= w_err_d;
            r_out_valid_q <= w_out_valid_d;
            r_in_ready_q  <= w_in_ready_d;
            r_busy_q      <= w_busy_d;
        end
    end

    assign in_ready  = r_in_ready_q;
    assign out_valid = r_out_valid_q;
    assign out_xs3   = r_result_q;
    assign out_err   = r_err_q;
    assign busy      = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_excess3_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_excess3_seq_ctrl
// Description : Directed self-checking bench for bcd_excess3_seq_ctrl
//               (NDIG = 4) with hand-computed Excess-3 results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_excess3_seq_ctrl;

    localparam int NDIG = 4;
    localparam int c_WAIT_MAX = 20;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [4*NDIG-1:0] in_bcd;
    logic              out_valid;
    logic              out_ready;
    logic [4*NDIG-1:0] out_xs3;
    logic              out_err;
    logic              busy;

    int n_checks;
    int n_fail;

    bcd_excess3_seq_ctrl #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_xs3   (out_xs3),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step until out_valid is seen or the budget expires; returns cycles waited.
    task automatic wait_out_valid(output int n);
        n = 0;
        while (!out_valid && n < c_WAIT_MAX) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_xs3 !== 16'h0)  begin n_fail++; $display("FAIL reset_out_xs3 got=%h exp=0000", out_xs3); end
        n_checks++; if (out_err !== 1'b0)   begin n_fail++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    // One complete conversion with out_ready held high.
    task automatic test_convert(input logic [15:0] bcd, input logic [15:0] exp_xs3,
                                input logic exp_err);
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bcd    = bcd;
        tick();
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL conv_accept_%h busy=%b in_ready=%b out_valid=%b exp=1/0/0", bcd, busy, in_ready, out_valid);
        end
        wait_out_valid(n);
        n_checks++; if (n !== NDIG) begin n_fail++; $display("FAIL conv_latency_%h got=%0d exp=%0d", bcd, n, NDIG); end
        n_checks++; if (out_xs3 !== exp_xs3) begin n_fail++; $display("FAIL conv_xs3_%h got=%h exp=%h", bcd, out_xs3, exp_xs3); end
        n_checks++; if (out_err !== exp_err) begin n_fail++; $display("FAIL conv_err_%h got=%b exp=%b", bcd, out_err, exp_err); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL conv_release_%h out_valid=%b in_ready=%b busy=%b exp=0/1/0", bcd, out_valid, in_ready, busy);
        end
        n_checks++; if (out_xs3 !== exp_xs3 || out_err !== exp_err) begin
            n_fail++; $display("FAIL conv_hold_idle_%h xs3=%h err=%b exp=%h/%b", bcd, out_xs3, out_err, exp_xs3, exp_err);
        end
    endtask

    task automatic test_basic();
        test_convert(16'h0369, 16'h369C, 1'b0);
    endtask

    task automatic test_digit_patterns();
        test_convert(16'h0A12, 16'h3D45, 1'b1);
        test_convert(16'hF000, 16'h2333, 1'b1);
        test_convert(16'h9999, 16'hCCCC, 1'b0);
        test_convert(16'h0000, 16'h3333, 1'b0);
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bcd    = 16'h1234;
        tick();
        in_valid = 1'b0;
        wait_out_valid(n);
        n_checks++; if (n !== NDIG) begin n_fail++; $display("FAIL bp_latency got=%0d exp=%0d", n, NDIG); end
        for (int c = 1; c <= 3; c++) begin
            n_checks++; if (out_valid !== 1'b1 || out_xs3 !== 16'h4567 || out_err !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_stall_cycle%0d valid=%b xs3=%h err=%b in_ready=%b exp=1/4567/0/0", c, out_valid, out_xs3, out_err, in_ready);
            end
            tick();
        end
        n_checks++; if (out_valid !== 1'b1 || out_xs3 !== 16'h4567) begin
            n_fail++; $display("FAIL bp_cycle4 valid=%b xs3=%h exp=1/4567", out_valid, out_xs3);
        end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_release valid=%b in_ready=%b busy=%b exp=0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bcd    = 16'h0369;
        tick();
        in_bcd = 16'h1111;  // keep offering a second word during CONV/DONE
        wait_out_valid(n);
        n_checks++; if (n !== NDIG) begin n_fail++; $display("FAIL b2b_latency1 got=%0d exp=%0d", n, NDIG); end
        n_checks++; if (out_xs3 !== 16'h369C || out_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first xs3=%h err=%b exp=369c/0", out_xs3, out_err);
        end
        tick();
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle in_ready=%b busy=%b valid=%b exp=1/0/0", in_ready, busy, out_valid);
        end
        tick();
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept2 busy=%b in_ready=%b exp=1/0", busy, in_ready);
        end
        wait_out_valid(n);
        n_checks++; if (n !== NDIG) begin n_fail++; $display("FAIL b2b_latency2 got=%0d exp=%0d", n, NDIG); end
        n_checks++; if (out_xs3 !== 16'h4444 || out_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second xs3=%h err=%b exp=4444/0", out_xs3, out_err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bcd    = 16'h0A12;
        tick();                 // accepted; first CONV cycle
        in_valid = 1'b0;
        tick();                 // second CONV cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ctrl in_ready=%b valid=%b busy=%b exp=1/0/0", in_ready, out_valid, busy);
        end
        n_checks++; if (out_xs3 !== 16'h0 || out_err !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_data xs3=%h err=%b exp=0000/0", out_xs3, out_err);
        end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_result got=%0d valid cycles exp=0", seen); end
        // Reset coinciding with an input handshake must win.
        rst = 1'b1; in_valid = 1'b1; in_bcd = 16'h5555;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_vs_handshake busy=%b in_ready=%b exp=0/1", busy, in_ready);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_digit_patterns();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=expired exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
